// File: rtl/lvds_tx_word_fifo.sv
// Word FIFO feeding the LVDS link transmitter: buffers 31-bit payload words and
// presents the head word with bit 31 forced high as a valid marker.
module lvds_tx_word_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          tx_inclock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic [30:0]   wr_data,
    input  logic          wr_en,
    output logic          wr_rdy,
    output logic [31:0]   enq_tx,
    output logic          RDY_enq_tx,
    input  logic          EN_enq_tx,
    output logic [AW:0]   count,
    output logic [15:0]   sent_cnt,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [30:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          push;
    logic          pop;

    // Handshakes: a push is accepted when wr_en && wr_rdy and a pop when
    // EN_enq_tx && RDY_enq_tx, both at the rising edge; ready flags depend only
    // on registered count, never on the request inputs.
    assign wr_rdy     = (count != FULL_CNT);
    assign RDY_enq_tx = (count != '0);
    assign push       = wr_en && wr_rdy;
    assign pop        = EN_enq_tx && RDY_enq_tx;
    assign enq_tx     = RDY_enq_tx ? {1'b1, mem[rp]} : 32'h0000_0000;

    always_ff @(posedge tx_inclock) begin
        if (reset_n && !flush && push) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge tx_inclock) begin
        if (!reset_n) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            sent_cnt  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp       <= rp + 1'b1;
                sent_cnt <= sent_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && !wr_rdy) begin
                overflow <= 1'b1;
            end
            if (EN_enq_tx && !RDY_enq_tx) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lvds_tx_word_fifo.sv
// Self-checking bench for lvds_tx_word_fifo: directed scenarios plus random
// traffic, every cycle compared against a queue-based reference model.
module tb_lvds_tx_word_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          tx_inclock = 1'b0;
    logic          reset_n    = 1'b0;
    logic          flush      = 1'b0;
    logic [30:0]   wr_data    = '0;
    logic          wr_en      = 1'b0;
    logic          wr_rdy;
    logic [31:0]   enq_tx;
    logic          RDY_enq_tx;
    logic          EN_enq_tx  = 1'b0;
    logic [AW:0]   count;
    logic [15:0]   sent_cnt;
    logic          overflow;
    logic          underflow;

    lvds_tx_word_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .tx_inclock (tx_inclock),
        .reset_n    (reset_n),
        .flush      (flush),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_rdy     (wr_rdy),
        .enq_tx     (enq_tx),
        .RDY_enq_tx (RDY_enq_tx),
        .EN_enq_tx  (EN_enq_tx),
        .count      (count),
        .sent_cnt   (sent_cnt),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 tx_inclock = ~tx_inclock;

    // Reference model: stored words in arrival order plus counters and flags.
    logic [30:0] model_q[$];
    int          m_sent;
    bit          m_ovf;
    bit          m_unf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit full;
        bit empty;
        if (!reset_n) begin
            model_q.delete();
            m_sent = 0;
            m_ovf  = 0;
            m_unf  = 0;
        end else if (flush) begin
            model_q.delete();
        end else begin
            full  = (model_q.size() == DEPTH);
            empty = (model_q.size() == 0);
            if (wr_en && full)      m_ovf = 1;
            if (EN_enq_tx && empty) m_unf = 1;
            if (EN_enq_tx && !empty) begin
                void'(model_q.pop_front());
                m_sent = (m_sent + 1) % 65536;
            end
            if (wr_en && !full) model_q.push_back(wr_data);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_head;
        exp_head = (model_q.size() > 0) ? {1'b1, model_q[0]} : 32'h0;
        check_eq("count",     32'(count),      32'(model_q.size()));
        check_eq("wr_rdy",    32'(wr_rdy),     32'(model_q.size() != DEPTH));
        check_eq("rdy",       32'(RDY_enq_tx), 32'(model_q.size() != 0));
        check_eq("enq_tx",    enq_tx,          exp_head);
        check_eq("sent_cnt",  32'(sent_cnt),   32'(m_sent));
        check_eq("overflow",  32'(overflow),   32'(m_ovf));
        check_eq("underflow", 32'(underflow),  32'(m_unf));
    endtask

    task automatic step();
        @(posedge tx_inclock);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic cycle(input bit w, input logic [30:0] d, input bit p, input bit f);
        wr_en     = w;
        wr_data   = d;
        EN_enq_tx = p;
        flush     = f;
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle(0, '0, 0, 0);
        cycle(0, '0, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        int pushed;
        int sent_before;

        // Reset state
        do_reset();
        check_eq("reset_wr_rdy", 32'(wr_rdy), 32'd1);
        check_eq("reset_rdy",    32'(RDY_enq_tx), 32'd0);
        check_eq("reset_enq",    enq_tx, 32'h0);

        // Single word through
        cycle(1, 31'h1234_5678, 0, 0);
        check_eq("single_head", enq_tx, 32'h9234_5678);
        check_eq("single_rdy",  32'(RDY_enq_tx), 32'd1);
        cycle(0, '0, 1, 0);
        check_eq("single_empty", enq_tx, 32'h0);
        check_eq("single_sent",  32'(sent_cnt), 32'd1);

        // Fill to full, push while full, drain in order
        for (int i = 0; i < 8; i++) cycle(1, 31'(i), 0, 0);
        cycle(1, 31'd9, 0, 0);
        check_eq("full_count", 32'(count), 32'd8);
        check_eq("full_wr_rdy", 32'(wr_rdy), 32'd0);
        check_eq("full_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("drain_head", enq_tx, 32'h8000_0000 | 32'(i));
            cycle(0, '0, 1, 0);
        end
        check_eq("drain_empty", 32'(RDY_enq_tx), 32'd0);

        // Simultaneous push+pop while empty
        cycle(1, 31'h0aa, 1, 0);
        check_eq("sim0_count", 32'(count), 32'd1);
        check_eq("sim0_unf", 32'(underflow), 32'd1);
        // At count = 3
        cycle(1, 31'h0bb, 0, 0);
        cycle(1, 31'h0cc, 0, 0);
        cycle(1, 31'h0dd, 1, 0);
        check_eq("sim3_count", 32'(count), 32'd3);
        // At count = 8
        for (int i = 0; i < 5; i++) cycle(1, 31'(32'h100 + i), 0, 0);
        cycle(1, 31'h1ff, 1, 0);
        check_eq("sim8_count", 32'(count), 32'd7);
        check_eq("sim8_ovf", 32'(overflow), 32'd1);

        // Pop while empty: sent_cnt and pointers unaffected
        for (int i = 0; i < 7; i++) cycle(0, '0, 1, 0);
        sent_before = m_sent;
        cycle(0, '0, 1, 0);
        check_eq("empty_pop_sent", 32'(sent_cnt), 32'(sent_before));
        cycle(1, 31'h5a5a, 0, 0);
        check_eq("empty_pop_head", enq_tx, 32'h8000_5a5a);
        cycle(0, '0, 1, 0);

        // 20-word stream with random gaps across pointer wrap
        pushed = 0;
        for (int c = 0; c < 600 && (pushed < 20 || model_q.size() > 0); c++) begin
            bit w;
            bit p;
            w = (pushed < 20) && ($urandom_range(0, 2) != 0);
            p = ($urandom_range(0, 2) == 0) && (model_q.size() > 0);
            if (w && model_q.size() < DEPTH) pushed++;
            else w = 0;
            cycle(w, 31'($urandom), p, 0);
            check_eq("stream_bound", 32'(count <= 4'd8), 32'd1);
        end
        check_eq("stream_drained", 32'(RDY_enq_tx), 32'd0);

        // Fully random traffic including occasional flush
        for (int c = 0; c < 400; c++) begin
            cycle(bit'($urandom_range(0, 1)), 31'($urandom),
                  bit'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
        end

        // Flush mid-stream with a simultaneous push
        cycle(0, '0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 31'(32'h300 + i), 0, 0);
        check_eq("pre_flush_count", 32'(count), 32'd5);
        sent_before = m_sent;
        cycle(1, 31'h3ff, 0, 1);
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_sent", 32'(sent_cnt), 32'(sent_before));
        check_eq("flush_ovf", 32'(overflow), 32'd1);
        check_eq("flush_unf", 32'(underflow), 32'd1);

        // Reset clears counters and flags
        do_reset();
        check_eq("rst_sent", 32'(sent_cnt), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_unf", 32'(underflow), 32'd0);
        cycle(0, '0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvds_tx_word_fifo.md
# lvds_tx_word_fifo

Upstream feeder for the LVDS link transmit path: buffers 31-bit payload words from the user logic and presents them, head-first, on the 32-bit `enq_tx` / `RDY_enq_tx` / `EN_enq_tx` dequeue interface that the LVDS link transmitter consumes. Bit 31 of every presented word is a forced valid marker. The far-end receiver uses this marker to discard idle (all-zero) frames. Runs entirely in the `tx_inclock` domain.

## Interface
Parameters:
- `DEPTH`, default 8: number of word entries; power of two, 2..64.
- `AW`, default 3: pointer width, equal to log2(`DEPTH`).

Ports:
- `tx_inclock`, in, 1: clock. All logic is clocked on the rising edge.
- `reset_n`, in, 1: reset; synchronous, active-low; clock `tx_inclock`.
- `flush`, in, 1: synchronous clear of stored words. Flags and counters are kept.
- `wr_data`, in, 31: payload word from user logic.
- `wr_en`, in, 1: push request.
- `wr_rdy`, out, 1: high when a push can be accepted, i.e. `count` is not equal to `DEPTH`.
- `enq_tx`, out, 32: head word to the link transmitter.
- `RDY_enq_tx`, out, 1: high when a head word is valid, i.e. the FIFO is non-empty.
- `EN_enq_tx`, in, 1: pop strobe from the link transmitter.
- `count`, out, `AW`+1: current number of stored words.
- `sent_cnt`, out, 16: number of words popped; wraps modulo 2^16.
- `overflow`, out, 1: sticky; set by a push attempted while full.
- `underflow`, out, 1: sticky; set by a pop strobe while empty.

## Operation
Storage:
- Circular register array of `DEPTH` entries × 31 bits.
- Write pointer `wp` and read pointer `rp`, each `AW` bits. Both wrap from `DEPTH`-1 to 0.

Head output:
- When `count` > 0: `enq_tx` = {1'b1, mem[rp]}. This is combinational from the registered state.
- When empty: `enq_tx` = 32'h0000_0000 and `RDY_enq_tx` = 0.

Push:
- Occurs when `wr_en` && `wr_rdy`: write `wr_data` to mem[wp], then `wp` increments by 1.
- `wr_en` while full: the data is dropped, `overflow` is set, and no state other than `overflow` changes.

Pop:
- Occurs when `EN_enq_tx` && `RDY_enq_tx`: `rp` increments by 1 and `sent_cnt` increments by 1.
- `EN_enq_tx` while empty: ignored, and `underflow` is set.

Simultaneous push and pop:
- Non-full, non-empty: both happen and `count` is unchanged.
- Empty: only the push happens, because the pop is invalid; `underflow` is set.
- Full: only the pop happens, because `wr_rdy` is low; `overflow` is set.

`flush`:
- `wp` = `rp` = `count` = 0 on the next edge.
- It overrides any push or pop in the same cycle.
- `sent_cnt`, `overflow` and `underflow` are unchanged.

Reset (`reset_n` low at an edge):
- `wp` = `rp` = 0, `count` = 0, `sent_cnt` = 0, `overflow` = 0, `underflow` = 0.
- Resulting outputs: `wr_rdy` = 1, `RDY_enq_tx` = 0, `enq_tx` = 0.
- Reset takes priority over `flush`, push and pop. Storage contents need not be cleared.

Sticky flags are cleared only by reset.

## Timing
- Push-to-visible latency is 1 cycle. A word pushed at edge k into an empty FIFO drives `enq_tx` and `RDY_enq_tx` = 1 from just after edge k.
- Pop takes effect at the edge where `EN_enq_tx` = 1. The next word, or empty, is presented after that edge.
- The head word is held stable for any number of cycles until it is popped. The transmitter samples `enq_tx` one edge before asserting `EN_enq_tx`; the held head guarantees the sampled and popped words are identical.
- `EN_enq_tx` is a single-cycle strobe per word. Each cycle it is held high counts as one pop.
- `wr_rdy` and `RDY_enq_tx` are derived combinationally from registered `count`. There is no combinational path from `wr_en` or `EN_enq_tx` to any output.
- Sustained throughput is one push and one pop per cycle.

## Test plan
- **Reset then single word.** Stimulus: reset, then push 31'h1234_5678. Required: the next cycle shows `enq_tx` = 32'h9234_5678 and `RDY_enq_tx` = 1; after one `EN_enq_tx` pulse, `enq_tx` = 0, `RDY_enq_tx` = 0 and `sent_cnt` = 1.
- **Fill to full.** Stimulus: push 8 words 0..7 with no pops, then push 9 while full. Required: `count` = 8, `wr_rdy` = 0, `overflow` = 1; popping 8 times returns 32'h8000_0000..32'h8000_0007 in order, and 9 never appears.
- **Pointer wrap.** Stimulus: a 20-word stream with random push/pop gaps. Required: output order equals input order with bit 31 set; `count` never exceeds 8.
- **Simultaneous events.** Stimulus: push and pop in the same cycle with `count` = 3, again with `count` = 8, and again with `count` = 0. Required, respectively: `count` stays 3; `count` goes to 7 with `overflow` = 1; `count` goes to 1 with `underflow` = 1.
- **Pop while empty.** Stimulus: pulse `EN_enq_tx` with the FIFO empty. Required: `underflow` = 1, `sent_cnt` unchanged, pointers unchanged.
- **Flush and reset mid-stream.** Stimulus: with `count` = 5, assert `flush` together with a push. Required: `count` = 0 next cycle, flags are kept, `sent_cnt` is kept. A subsequent `reset_n` pulse clears `sent_cnt`, `overflow` and `underflow` to 0.
